// File: rtl/clint_mh_if.sv
// Memory-mapped en/we slave bus between a core and the CLINT.
// A transfer is a one-cycle en_i pulse, answered one cycle later by data_ready_o.
interface clint_mh_if #(
    parameter int XLEN = 32
);
    logic            en_i;
    logic            we_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] data_i;
    logic [XLEN-1:0] data_o;
    logic            data_ready_o;

    modport master (
        output en_i, we_i, addr_i, data_i,
        input  data_o, data_ready_o
    );

    modport slave (
        input  en_i, we_i, addr_i, data_i,
        output data_o, data_ready_o
    );
endinterface

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared prescaled 64-bit mtime, per-hart
// mtimecmp/msip, and registered timer/software interrupt lines.
module clint_mh #(
    parameter int XLEN     = 32,
    parameter int NHARTS   = 4,
    parameter int TICK_DIV = 100_000,
    parameter int DIV_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    clint_mh_if.slave         bus,
    output logic [NHARTS-1:0] tmr_irq_o,
    output logic [NHARTS-1:0] sft_irq_o
);

    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q [NHARTS];
    logic [63:0]       mtimecmp_d [NHARTS];
    logic [NHARTS-1:0] msip_q, msip_d;
    logic              ctrl_en_q, ctrl_en_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic [NHARTS-1:0] tmr_q, tmr_d;
    logic [NHARTS-1:0] sft_q, sft_d;

    logic [13:0]     wa;
    logic            wr, rd, tick;
    logic            is_msip, is_cmp, is_mtlo, is_mthi, is_ctrl, is_div;
    logic [XLEN-1:0] rdata;
    logic            unused_addr;

    assign wa          = bus.addr_i[15:2];
    assign unused_addr = ^{bus.addr_i[XLEN-1:16], bus.addr_i[1:0]};

    always_comb begin
        wr      = bus.en_i & bus.we_i;
        rd      = bus.en_i & ~bus.we_i;
        is_msip = (wa[13:12] == 2'b00);
        is_cmp  = (wa[13:12] == 2'b01);
        is_mtlo = (wa == 14'h2FFE);
        is_mthi = (wa == 14'h2FFF);
        is_ctrl = (wa == 14'h3000);
        is_div  = (wa == 14'h3001);

        // DIV of 0 or 1 ticks every enabled cycle; the prescaler then stays at 0
        tick = ctrl_en_q && ((div_q <= DIV_W'(1)) || (presc_q == div_q - DIV_W'(1)));

        presc_d = presc_q;
        if (ctrl_en_q) presc_d = tick ? '0 : presc_q + DIV_W'(1);
        if (wr && is_div) presc_d = '0;

        // A software write to either half overrides a coincident tick
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr && is_mtlo) mtime_d = {mtime_q[63:32], bus.data_i};
        if (wr && is_mthi) mtime_d = {bus.data_i, mtime_q[31:0]};

        ctrl_en_d  = (wr && is_ctrl) ? bus.data_i[0] : ctrl_en_q;
        div_d      = (wr && is_div) ? DIV_W'(bus.data_i) : div_q;
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        rdata      = '0;

        for (int h = 0; h < NHARTS; h++) begin
            if (is_msip && (wa[11:0] == 12'(h))) begin
                if (wr) msip_d[h] = bus.data_i[0];
                rdata = {{(XLEN-1){1'b0}}, msip_q[h]};
            end
            if (is_cmp && (wa[11:1] == 11'(h))) begin
                if (wr && wa[0])  mtimecmp_d[h][63:32] = bus.data_i;
                if (wr && !wa[0]) mtimecmp_d[h][31:0]  = bus.data_i;
                rdata = wa[0] ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
            end
            tmr_d[h] = (mtime_q >= mtimecmp_q[h]);
        end

        if (is_mtlo) rdata = mtime_q[31:0];
        if (is_mthi) rdata = mtime_q[63:32];
        if (is_ctrl) rdata = {{(XLEN-1){1'b0}}, ctrl_en_q};
        if (is_div)  rdata = XLEN'(div_q);

        rdata_d = rd ? rdata : rdata_q;
        ready_d = bus.en_i;
        sft_d   = msip_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q   <= '0;
            for (int h = 0; h < NHARTS; h++) mtimecmp_q[h] <= '1;
            msip_q    <= '0;
            ctrl_en_q <= 1'b1;
            div_q     <= DIV_W'(TICK_DIV);
            presc_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            tmr_q     <= '0;
            sft_q     <= '0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            ctrl_en_q  <= ctrl_en_d;
            div_q      <= div_d;
            presc_q    <= presc_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            tmr_q      <= tmr_d;
            sft_q      <= sft_d;
        end
    end

    assign bus.data_o       = rdata_q;
    assign bus.data_ready_o = ready_q;
    assign tmr_irq_o        = tmr_q;
    assign sft_irq_o        = sft_q;

endmodule

// File: tb/tb_clint_mh.sv
// Directed bench for clint_mh: accesses push expected responses into a queue,
// and an independent monitor pops and checks them when data_ready_o appears.
module tb_clint_mh;
    localparam int XLEN = 32, NHARTS = 4, TICK_DIV = 100_000, DIV_W = 32;
    localparam logic [31:0] A_MTLO = 32'hBFF8, A_MTHI = 32'hBFFC;
    localparam logic [31:0] A_CTRL = 32'hC000, A_DIV = 32'hC004;

    logic clk = 1'b0;
    logic rst;
    logic [NHARTS-1:0] tmr, sft;

    clint_mh_if #(.XLEN(XLEN)) bus();

    clint_mh #(.XLEN(XLEN), .NHARTS(NHARTS), .TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .tmr_irq_o(tmr), .sft_irq_o(sft)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding access
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.data_ready_o === 1'b1) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL spurious_ready: data_ready_o=1, expected 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_lat"}, 64'(cyc), 64'(e.cyc));
                    chk(e.name, bus.data_o, e.exp);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                total_cnt++;
                $display("FAIL %s_ready: data_ready_o=0, expected 1", e.name);
            end
        end
    end

    task automatic acc(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input string nm);
        exp_t e;
        bus.en_i   = 1'b1;
        bus.we_i   = we;
        bus.addr_i = a;
        bus.data_i = d;
        e.exp  = we ? last_rd : exp;
        e.cyc  = cyc + 1;
        e.name = nm;
        sb.push_back(e);
        if (!we) last_rd = exp;
        @(posedge clk); #1;
        bus.en_i = 1'b0;
        bus.we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
        acc(1'b1, a, d, 32'h0, nm);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        acc(1'b0, a, 32'h0, exp, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.en_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_data_o", bus.data_o, 0);
        chk("rst_ready", bus.data_ready_o, 0);
        chk("rst_tmr", tmr, 0);
        chk("rst_sft", sft, 0);
        @(posedge clk); #1;

        // Reset values
        rd(32'h4010, 32'hFFFF_FFFF, "cmp2_lo_rst");
        rd(32'h4014, 32'hFFFF_FFFF, "cmp2_hi_rst");
        rd(A_CTRL, 32'h1, "ctrl_rst");
        rd(A_DIV, TICK_DIV, "div_rst");
        rd(A_MTLO, 32'h0, "mtlo_rst");

        // DIV=4: ticks on edges 4,8,..,40 after the DIV write, frozen by CTRL=0 at edge 40
        wr(A_DIV, 32'd4, "wr_div4");
        idle(39);
        wr(A_CTRL, 32'h0, "wr_ctrl0");
        rd(A_MTLO, 32'd10, "mtlo_div4");
        rd(A_MTHI, 32'd0, "mthi_div4");
        idle(20);
        rd(A_MTLO, 32'd10, "mtlo_frozen");

        // Carry from lo into hi
        wr(A_MTLO, 32'hFFFF_FFFE, "wr_mtlo");
        wr(A_MTHI, 32'h0, "wr_mthi");
        wr(A_DIV, 32'd1, "wr_div1");
        wr(A_CTRL, 32'h1, "wr_ctrl1");
        idle(1);
        wr(A_CTRL, 32'h0, "wr_ctrl0b");
        rd(A_MTLO, 32'h0, "mtlo_carry");
        rd(A_MTHI, 32'h1, "mthi_carry");

        // All-ones mtime fires every hart, then wraps to zero
        wr(A_MTLO, 32'hFFFF_FFFF, "wr_mtlo_ones");
        wr(A_MTHI, 32'hFFFF_FFFF, "wr_mthi_ones");
        @(negedge clk);
        @(negedge clk);
        chk("tmr_all_ones", tmr, 4'b1111);
        @(posedge clk); #1;
        wr(A_CTRL, 32'h1, "wr_ctrl1b");
        wr(A_CTRL, 32'h0, "wr_ctrl0c");
        rd(A_MTLO, 32'h0, "mtlo_wrap");
        rd(A_MTHI, 32'h0, "mthi_wrap");

        // mtimecmp[1]=5 with mtime counting up from 0, one tick per cycle
        wr(32'h400C, 32'h0, "wr_cmp1_hi");
        wr(32'h4008, 32'd5, "wr_cmp1_lo");
        wr(A_CTRL, 32'h1, "wr_ctrl1c");
        repeat (6) @(negedge clk);
        chk("tmr_before", tmr, 4'b0000);
        @(negedge clk);
        chk("tmr_rise", tmr, 4'b0010);
        @(posedge clk); #1;
        wr(32'h400C, 32'hFFFF_FFFF, "wr_cmp1_hi_ones");
        @(negedge clk);
        chk("tmr_hold", tmr, 4'b0010);
        @(negedge clk);
        chk("tmr_fall", tmr, 4'b0000);
        @(posedge clk); #1;

        // msip[3]
        wr(32'h000C, 32'hFFFF_FFFF, "wr_msip3");
        @(negedge clk);
        chk("sft_before", sft, 4'b0000);
        @(negedge clk);
        chk("sft_set", sft, 4'b1000);
        @(posedge clk); #1;
        rd(32'h000C, 32'h1, "msip3_rd");
        wr(32'h000C, 32'h0, "wr_msip3_0");
        @(negedge clk);
        chk("sft_hold", sft, 4'b1000);
        @(negedge clk);
        chk("sft_clr", sft, 4'b0000);
        @(posedge clk); #1;

        // Unmapped and out-of-range hart
        rd(32'h8000, 32'h0, "unmapped_rd");
        wr(32'h8000, 32'hDEAD_BEEF, "unmapped_wr");
        rd(32'h8000, 32'h0, "unmapped_rd2");
        rd(32'h0010, 32'h0, "msip4_rd");
        wr(32'h0010, 32'h1, "wr_msip4");
        wr(32'h4020, 32'h0, "wr_cmp4_lo");
        wr(32'h4024, 32'h0, "wr_cmp4_hi");
        idle(2);
        chk("sft_oob", sft, 4'b0000);
        chk("tmr_oob", tmr, 4'b0000);
        rd(32'h0000, 32'h0, "msip0_rd");
        rd(32'h4000, 32'hFFFF_FFFF, "cmp0_lo_rd");
        rd(32'h4004, 32'hFFFF_FFFF, "cmp0_hi_rd");

        // mtime writes coincident with a tick (CTRL=1, DIV=1 still running)
        wr(A_MTLO, 32'h100, "wr_mtlo_tick");
        wr(A_CTRL, 32'h0, "wr_ctrl0d");
        rd(A_MTLO, 32'h101, "mtlo_tick");
        wr(A_CTRL, 32'h1, "wr_ctrl1d");
        wr(A_MTHI, 32'h7, "wr_mthi_tick");
        wr(A_CTRL, 32'h0, "wr_ctrl0e");
        rd(A_MTLO, 32'h102, "mtlo_tick2");
        rd(A_MTHI, 32'h7, "mthi_tick2");
        idle(3);

        // Reset arriving together with an access
        bus.en_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = A_CTRL;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.en_i = 1'b0;
        @(negedge clk);
        chk("midrst_ready", bus.data_ready_o, 0);
        chk("midrst_data_o", bus.data_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = '0;
        rd(A_CTRL, 32'h1, "ctrl_rst2");
        rd(A_DIV, TICK_DIV, "div_rst2");
        rd(A_MTHI, 32'h0, "mthi_rst2");
        rd(32'h400C, 32'hFFFF_FFFF, "cmp1_hi_rst2");
        idle(3);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
